// File: rtl/bpu_pht_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bpu_pht_update_scheduler
// Description : Write-port scheduler for the bimodal PHT. Accepts up to two
//               resolved conditional-branch outcomes per cycle (lane 0 older,
//               lane 1 younger). They are queued as {idx, taken} in a small
//               FIFO, and at most one counter update is issued per cycle on
//               the single PHT write port. On request, it also sequences a
//               full-table clear, one index per cycle.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_upd{0,1}_*       - lane resolve valid / direction / PC
//               i_clear_req        - pulse, clear whole PHT to 2'b00
//               o_clear_busy       - clear sequence in progress
//               o_pht_wr_*         - PHT write strobe, index, direction, clear
//               o_stat_drop_cnt    - dropped lane updates (saturating)
//               o_stat_wr_cnt      - issued counter updates (wrapping)
// Options     : BPU_PHT_STATS_EN   - when defined, the statistics counters
//                                    are built; otherwise both ports are 0
// Revision    : 1.0 - initial release
// ============================================================================
module bpu_pht_update_scheduler #(
    parameter int PHT_WIDTH  = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int PC_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_upd0_valid,
    input  logic                 i_upd0_taken,
    input  logic [PC_WIDTH-1:0]  i_upd0_pc,
    input  logic                 i_upd1_valid,
    input  logic                 i_upd1_taken,
    input  logic [PC_WIDTH-1:0]  i_upd1_pc,
    input  logic                 i_clear_req,
    output logic                 o_clear_busy,
    output logic                 o_pht_wr_en,
    output logic [PHT_WIDTH-1:0] o_pht_wr_idx,
    output logic                 o_pht_wr_taken,
    output logic                 o_pht_wr_clear,
    output logic [15:0]          o_stat_drop_cnt,
    output logic [31:0]          o_stat_wr_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [PHT_WIDTH-1:0] c_last_idx = {PHT_WIDTH{1'b1}};
    localparam logic [CW:0]          c_depth    = (CW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]           r_state;
    logic [PHT_WIDTH-1:0] r_clr_idx;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic [PHT_WIDTH-1:0] r_fifo_idx [FIFO_DEPTH];
    logic                 r_fifo_tkn [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational scheduling
    // ------------------------------------------------------------------
    logic                 w_idle;
    logic                 w_clr_start;
    logic                 w_accept;
    logic                 w_pop;
    logic [CW:0]          w_free;
    logic                 w_push0;
    logic                 w_push1;
    logic [AW-1:0]        w_wr_ptr1;
    logic [1:0]           w_drop_lanes;
    logic [PHT_WIDTH-1:0] w_idx0;
    logic [PHT_WIDTH-1:0] w_idx1;

    assign w_idx0 = i_upd0_pc[PHT_WIDTH+1:2];
    assign w_idx1 = i_upd1_pc[PHT_WIDTH+1:2];

    assign w_idle      = (r_state == S_IDLE);
    assign w_clr_start = w_idle & i_clear_req;
    // New updates are only taken in IDLE on a cycle without a clear request.
    assign w_accept    = w_idle & ~i_clear_req;
    // The head write is suppressed on the clear-request cycle: the whole
    // queue is being discarded and the table is about to be wiped anyway.
    assign w_pop       = w_accept & (r_count != '0);

    assign w_free = c_depth - {1'b0, r_count} + {{CW{1'b0}}, w_pop};

    // Lane 0 has priority for the last free slot.
    assign w_push0 = w_accept & i_upd0_valid & (w_free >= (CW+1)'(1));
    assign w_push1 = w_accept & i_upd1_valid &
                     (i_upd0_valid ? (w_free >= (CW+1)'(2)) : (w_free >= (CW+1)'(1)));

    assign w_wr_ptr1    = r_wr_ptr + AW'(w_push0);
    assign w_drop_lanes = {1'b0, i_upd0_valid & ~w_push0} +
                          {1'b0, i_upd1_valid & ~w_push1};

    // ------------------------------------------------------------------
    // Control state, pointers and clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_idx == c_last_idx) begin
                r_state   <= S_IDLE;
                r_clr_idx <= '0;
            end else begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end else if (w_clr_start) begin
            // Flush the queue; it stays empty for the whole clear sequence.
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
            r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
        end
    end

    // FIFO storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_fifo_idx[r_wr_ptr] <= w_idx0;
            r_fifo_tkn[r_wr_ptr] <= i_upd0_taken;
        end
        if (w_push1) begin
            r_fifo_idx[w_wr_ptr1] <= w_idx1;
            r_fifo_tkn[w_wr_ptr1] <= i_upd1_taken;
        end
    end

    // ------------------------------------------------------------------
    // PHT write port
    // ------------------------------------------------------------------
    always_comb begin
        o_clear_busy   = 1'b0;
        o_pht_wr_en    = 1'b0;
        o_pht_wr_idx   = '0;
        o_pht_wr_taken = 1'b0;
        o_pht_wr_clear = 1'b0;
        if (r_state == S_CLEAR) begin
            o_clear_busy   = 1'b1;
            o_pht_wr_en    = 1'b1;
            o_pht_wr_idx   = r_clr_idx;
            o_pht_wr_clear = 1'b1;
        end else if (w_pop) begin
            o_pht_wr_en    = 1'b1;
            o_pht_wr_idx   = r_fifo_idx[r_rd_ptr];
            o_pht_wr_taken = r_fifo_tkn[r_rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BPU_PHT_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (r_drop_cnt > (16'hFFFF - {14'd0, w_drop_lanes}))
                r_drop_cnt <= 16'hFFFF;
            else
                r_drop_cnt <= r_drop_cnt + {14'd0, w_drop_lanes};
            r_wr_cnt <= r_wr_cnt + {31'd0, w_pop};
        end
    end

    assign o_stat_drop_cnt = r_drop_cnt;
    assign o_stat_wr_cnt   = r_wr_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats  = ^w_drop_lanes;
    assign o_stat_drop_cnt = '0;
    assign o_stat_wr_cnt   = '0;
`endif

    // PC bits outside the index field are not needed.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{i_upd0_pc[PC_WIDTH-1:PHT_WIDTH+2], i_upd0_pc[1:0],
                                i_upd1_pc[PC_WIDTH-1:PHT_WIDTH+2], i_upd1_pc[1:0]};

endmodule
`default_nettype wire
